// File: rtl/axis_to_dac_interface_pkg.sv
// axis_to_dac_interface_pkg: shared playback FSM encoding and level width helper
package axis_to_dac_interface_pkg;
  typedef enum logic [1:0] {IDLE, PREFILL, STREAM} state_t;
  function automatic int level_width(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/axis_to_dac_interface_if.sv
// axis_to_dac_interface_if: AXI-Stream sample bus with tlast
interface axis_to_dac_interface_if #(parameter int DATA_WIDTH = 32);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_to_dac_interface_fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock first-word-fall-through FIFO with occupancy counter
module fifo_sync_fwft #(
  parameter int DATA_WIDTH = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic                        i_wen,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_ren,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic we, re;
  assign o_empty = o_level == '0;
  assign o_full  = o_level == (AW+1)'(FIFO_DEPTH);
  assign we      = i_wen & !o_full;
  assign re      = i_ren & !o_empty;
  assign o_data  = mem[rptr];
  always_ff @(posedge clk) begin
    if (i_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      o_level <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      o_level <= o_level + (AW+1)'(we) - (AW+1)'(re);
    end
  end
  always_ff @(posedge clk)
    if (we) mem[wptr] <= i_data;
endmodule

// File: rtl/axis_to_dac_interface.sv
// axis_to_dac_interface: buffers AXIS samples and plays them to a DAC one per clock,
// with prefill threshold, underrun detection and sticky status.
module axis_to_dac_interface import axis_to_dac_interface_pkg::*; #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FIFO_DEPTH  = 16,
  parameter int                    START_LEVEL = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE  = '0
) (
  input  logic                                clk,
  input  logic                                i_rst,
  axis_to_dac_interface_if.slave              s_axis,
  output logic [DATA_WIDTH-1:0]               o_dac_data,
  output logic                                o_dac_valid,
  output logic                                o_dac_last,
  input  logic                                i_con_axisside,
  input  logic                                i_con_dacside,
  input  logic                                i_clr_status,
  output logic [level_width(FIFO_DEPTH)-1:0]  o_level,
  output logic                                o_status_full,
  output logic                                o_status_underrun
);
  localparam int LW = level_width(FIFO_DEPTH);
  state_t state, state_nxt;
  logic wr, ren, under, empty, full;
  logic [DATA_WIDTH:0] rd_data;
  logic [LW:0] lvl_nxt;
  assign s_axis.tready = i_con_axisside & !full & !i_rst;
  assign wr            = s_axis.tvalid & s_axis.tready;
  assign o_status_full = full;
  // Prefill looks at the post-write level so playback starts the cycle after the threshold is hit
  assign lvl_nxt       = {1'b0, o_level} + (LW+1)'(wr);
  fifo_sync_fwft #(.DATA_WIDTH(DATA_WIDTH + 1), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wen   (wr),
    .i_data  ({s_axis.tlast, s_axis.tdata}),
    .i_ren   (ren),
    .o_data  (rd_data),
    .o_empty (empty),
    .o_full  (full),
    .o_level (o_level)
  );
  always_comb begin
    ren       = state == STREAM && i_con_dacside && !empty;
    under     = state == STREAM && i_con_dacside && empty;
    state_nxt = !i_con_dacside  ? IDLE :
                state == IDLE    ? PREFILL :
                state == PREFILL ? (lvl_nxt >= (LW+1)'(START_LEVEL) ? STREAM : PREFILL) :
                under            ? PREFILL : STREAM;
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state             <= IDLE;
      o_dac_data        <= IDLE_VALUE;
      o_dac_valid       <= 1'b0;
      o_dac_last        <= 1'b0;
      o_status_underrun <= 1'b0;
    end else begin
      state             <= state_nxt;
      o_dac_data        <= ren ? rd_data[DATA_WIDTH-1:0] : IDLE_VALUE;
      o_dac_valid       <= ren;
      o_dac_last        <= ren & rd_data[DATA_WIDTH];
      o_status_underrun <= under | (o_status_underrun & !i_clr_status);
    end
  end
endmodule
